// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / data) for one shared memory port.
// Optional round-robin arbitration under MEM_ARB_RR_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_ubhw,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_ubhw,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        if_stall,
  output logic        d_stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_IF,
    GNT_D
  } state_t;

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LIM_I =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LIMIT = CW'(LIM_I);
  localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic        if_elig, d_elig;
  logic        gnt_if, gnt_d, load;
  logic        tmo;
  logic        if_done_n, d_done_n, err_n;
  logic [31:0] if_rdata_n, d_rdata_n;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  ubhw_q;

`ifdef MEM_ARB_RR_EN
  logic last_d;
`endif

  // A requester completing this cycle still shows its old req.
  always_comb begin
    if_elig = if_req & ~if_done;
    d_elig  = d_req & ~d_done;
    gnt_d   = 1'b0;
    gnt_if  = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (if_elig && d_elig) begin
      gnt_d  = ~last_d;
      gnt_if = last_d;
    end else begin
      gnt_d  = d_elig;
      gnt_if = if_elig;
    end
`else
    gnt_d  = d_elig;
    gnt_if = if_elig & ~d_elig;
`endif
  end

  assign load = (state == IDLE) & (gnt_d | gnt_if);
  assign tmo  = TMO_EN & ~m_ack & (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    if_done_n  = 1'b0;
    d_done_n   = 1'b0;
    err_n      = 1'b0;
    if_rdata_n = '0;
    d_rdata_n  = '0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        unique case (1'b1)
          gnt_d:   state_n = GNT_D;
          gnt_if:  state_n = GNT_IF;
          default: state_n = IDLE;
        endcase
      end
      GNT_IF: begin
        if (m_ack) begin
          state_n    = IDLE;
          if_done_n  = 1'b1;
          if_rdata_n = m_rdata;
        end else if (tmo) begin
          state_n   = IDLE;
          if_done_n = 1'b1;
          err_n     = 1'b1;
        end else if (TMO_EN) begin
          cnt_n = cnt + 1'b1;
        end
      end
      GNT_D: begin
        if (m_ack) begin
          state_n   = IDLE;
          d_done_n  = 1'b1;
          d_rdata_n = we_q ? 32'd0 : m_rdata;
        end else if (tmo) begin
          state_n  = IDLE;
          d_done_n = 1'b1;
          err_n    = 1'b1;
        end else if (TMO_EN) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ubhw_q  <= '0;
    end else if (load) begin
      we_q    <= gnt_d & d_we;
      addr_q  <= gnt_d ? d_addr : if_addr;
      wdata_q <= gnt_d ? d_wdata : 32'd0;
      ubhw_q  <= gnt_d ? d_ubhw : 3'b010;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (load) begin
      last_d <= gnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      bus_err  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_done  <= if_done_n;
      d_done   <= d_done_n;
      bus_err  <= err_n;
      if_rdata <= if_rdata_n;
      d_rdata  <= d_rdata_n;
    end
  end

  assign m_req    = (state != IDLE);
  assign m_we     = m_req & we_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign m_ubhw   = ubhw_q;
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, timeout, reset.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_ubhw;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_ubhw;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        if_stall;
  logic        d_stall;
  logic        bus_err;

  int total;
  int bad;

  mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ubhw(d_ubhw),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ubhw(m_ubhw),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .if_stall(if_stall), .d_stall(d_stall),
    .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_ubhw  = 3'b010;
    m_ack   = 1'b0;
    m_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    quiet();
    #3;
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rst_mreq got=%h exp=0", m_req); end
    total++; if (m_we !== 1'b0) begin bad++; $display("FAIL rst_mwe got=%h exp=0", m_we); end
    total++; if (m_addr !== 32'd0) begin bad++; $display("FAIL rst_maddr got=%h exp=0", m_addr); end
    total++; if (m_wdata !== 32'd0) begin bad++; $display("FAIL rst_mwdata got=%h exp=0", m_wdata); end
    total++; if (m_ubhw !== 3'd0) begin bad++; $display("FAIL rst_mubhw got=%h exp=0", m_ubhw); end
    total++; if ({if_done, d_done, bus_err} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b exp=000", {if_done, d_done, bus_err}); end
    total++; if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h04;
    #1;
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL fetch_stall0 got=%h exp=1", if_stall); end
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL fetch_mreq0 got=%h exp=0", m_req); end
    tick();
    total++; if (m_req !== 1'b1) begin bad++; $display("FAIL fetch_mreq1 got=%h exp=1", m_req); end
    total++; if (m_addr !== 32'h04) begin bad++; $display("FAIL fetch_maddr got=%h exp=4", m_addr); end
    total++; if (m_we !== 1'b0) begin bad++; $display("FAIL fetch_mwe got=%h exp=0", m_we); end
    total++; if (m_ubhw !== 3'b010) begin bad++; $display("FAIL fetch_ubhw got=%h exp=2", m_ubhw); end
    m_ack = 1'b1; m_rdata = 32'h00A00093;
    tick();
    m_ack = 1'b0; m_rdata = 32'h0;
    total++; if (if_done !== 1'b1) begin bad++; $display("FAIL fetch_done got=%h exp=1", if_done); end
    total++; if (if_rdata !== 32'h00A00093) begin bad++; $display("FAIL fetch_rdata got=%h exp=00a00093", if_rdata); end
    total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL fetch_stall2 got=%h exp=0", if_stall); end
    total++; if (m_req !== 1'b0 || d_done !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL fetch_c2 got=%b exp=000", {m_req, d_done, bus_err}); end
    if_req = 1'b0;
    tick();
    total++; if (if_done !== 1'b0) begin bad++; $display("FAIL fetch_done3 got=%h exp=0", if_done); end
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20;
    d_wdata = 32'hDEADBEEF; d_ubhw = 3'b010;
    tick();
    total++; if (m_req !== 1'b1 || m_we !== 1'b1) begin bad++; $display("FAIL b2b_dreq got=%b exp=11", {m_req, m_we}); end
    total++; if (m_addr !== 32'h20) begin bad++; $display("FAIL b2b_daddr got=%h exp=20", m_addr); end
    total++; if (m_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_wdata got=%h exp=deadbeef", m_wdata); end
    total++; if (if_stall !== 1'b1 || d_stall !== 1'b1) begin bad++; $display("FAIL b2b_stalls got=%b exp=11", {if_stall, d_stall}); end
    m_ack = 1'b1; m_rdata = 32'h77777777;
    tick();
    total++; if (d_done !== 1'b1 || if_done !== 1'b0) begin bad++; $display("FAIL b2b_ddone got=%b exp=10", {d_done, if_done}); end
    total++; if (d_rdata !== 32'd0) begin bad++; $display("FAIL b2b_store_rdata got=%h exp=0", d_rdata); end
    d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
    tick();
    total++; if (m_req !== 1'b1 || m_we !== 1'b0) begin bad++; $display("FAIL b2b_ifreq got=%b exp=10", {m_req, m_we}); end
    total++; if (m_addr !== 32'h10) begin bad++; $display("FAIL b2b_ifaddr got=%h exp=10", m_addr); end
    m_ack = 1'b1; m_rdata = 32'h13;
    tick();
    total++; if (if_done !== 1'b1 || d_done !== 1'b0) begin bad++; $display("FAIL b2b_ifdone got=%b exp=10", {if_done, d_done}); end
    total++; if (if_rdata !== 32'h13) begin bad++; $display("FAIL b2b_ifrdata got=%h exp=13", if_rdata); end
    quiet();
    tick();
  endtask

  task automatic test_priority();
    logic [31:0] first_addr;
    logic [31:0] second_addr;
`ifdef MEM_ARB_RR_EN
    first_addr = 32'h44; second_addr = 32'h48;
`else
    first_addr = 32'h48; second_addr = 32'h44;
`endif
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    m_ack = 1'b1; m_rdata = 32'h55;
    tick();
    total++; if (d_done !== 1'b1 || d_rdata !== 32'h55) begin bad++; $display("FAIL prio_load got=%b/%h exp=1/55", d_done, d_rdata); end
    d_req = 1'b0; m_ack = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_addr = 32'h48;
    tick();
    total++; if (m_addr !== first_addr) begin bad++; $display("FAIL prio_first got=%h exp=%h", m_addr, first_addr); end
    m_ack = 1'b1;
    tick();
    total++; if ((if_done | d_done) !== 1'b1 || (if_done & d_done) !== 1'b0) begin bad++; $display("FAIL prio_done1 got=%b exp=one-hot", {if_done, d_done}); end
    m_ack = 1'b0;
    tick();
    total++; if (m_addr !== second_addr) begin bad++; $display("FAIL prio_second got=%h exp=%h", m_addr, second_addr); end
    m_ack = 1'b1;
    tick();
    quiet();
    tick();
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    m_ack = 1'b0; m_rdata = 32'h1234;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total++; if (m_req !== 1'b1 || d_done !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL tmo_wait%0d got=%b exp=100", i, {m_req, d_done, bus_err}); end
    end
    tick();
    total++; if (d_done !== 1'b1 || bus_err !== 1'b1) begin bad++; $display("FAIL tmo_pulse got=%b exp=11", {d_done, bus_err}); end
    total++; if (d_rdata !== 32'd0 || m_req !== 1'b0) begin bad++; $display("FAIL tmo_rdata got=%h/%b exp=0/0", d_rdata, m_req); end
    d_req = 1'b0;
    tick();
    total++; if (bus_err !== 1'b0 || d_done !== 1'b0) begin bad++; $display("FAIL tmo_after got=%b exp=00", {bus_err, d_done}); end
    quiet();
  endtask

  task automatic test_ack_last();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84;
    for (int i = 1; i <= 16; i++) tick();
    total++; if (m_req !== 1'b1) begin bad++; $display("FAIL acklast_mreq got=%h exp=1", m_req); end
    m_ack = 1'b1; m_rdata = 32'hCAFE0001;
    tick();
    total++; if (d_done !== 1'b1 || bus_err !== 1'b0) begin bad++; $display("FAIL acklast_done got=%b exp=10", {d_done, bus_err}); end
    total++; if (d_rdata !== 32'hCAFE0001) begin bad++; $display("FAIL acklast_rdata got=%h exp=cafe0001", d_rdata); end
    quiet();
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'hC0;
    tick();
    total++; if (m_req !== 1'b1) begin bad++; $display("FAIL rmid_mreq got=%h exp=1", m_req); end
    tick();
    #2 rst = 1'b0;
    if_req = 1'b0;
    #1;
    total++; if (m_req !== 1'b0 || m_addr !== 32'd0) begin bad++; $display("FAIL rmid_abort got=%b/%h exp=0/0", m_req, m_addr); end
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (if_done !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL rmid_post%0d got=%b exp=00", i, {if_done, m_req}); end
    end
    if_req = 1'b1; if_addr = 32'hC4;
    tick();
    total++; if (m_req !== 1'b1 || m_addr !== 32'hC4) begin bad++; $display("FAIL rmid_rearb got=%b/%h exp=1/c4", m_req, m_addr); end
    m_ack = 1'b1; m_rdata = 32'h99;
    tick();
    total++; if (if_done !== 1'b1 || if_rdata !== 32'h99) begin bad++; $display("FAIL rmid_done got=%b/%h exp=1/99", if_done, if_rdata); end
    quiet();
    tick();
  endtask

  task automatic test_rereq();
    if_req = 1'b1; if_addr = 32'h04;
    tick();
    m_ack = 1'b1; m_rdata = 32'h11;
    tick();
    total++; if (if_done !== 1'b1) begin bad++; $display("FAIL rereq_done1 got=%h exp=1", if_done); end
    if_addr = 32'h08; m_ack = 1'b0;
    tick();
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rereq_nogrant got=%h exp=0", m_req); end
    tick();
    total++; if (m_req !== 1'b1 || m_addr !== 32'h08) begin bad++; $display("FAIL rereq_grant got=%b/%h exp=1/08", m_req, m_addr); end
    m_ack = 1'b1; m_rdata = 32'h22;
    tick();
    total++; if (if_done !== 1'b1 || if_rdata !== 32'h22) begin bad++; $display("FAIL rereq_done2 got=%b/%h exp=1/22", if_done, if_rdata); end
    quiet();
    tick();
  endtask

  task automatic test_stray_ack();
    m_ack = 1'b1; m_rdata = 32'hFFFF;
    tick();
    tick();
    total++; if ({if_done, d_done, bus_err, m_req} !== 4'b0000) begin bad++; $display("FAIL stray_ack got=%b exp=0000", {if_done, d_done, bus_err, m_req}); end
    quiet();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fetch();
    test_back_to_back();
    test_priority();
    test_timeout();
    test_ack_last();
    test_reset_mid();
    test_rereq();
    test_stray_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, cycles a granted access may wait for m_ack before abort (0 = no timeout).
REQ-002 clk  in  1  main (debug-gated) clock; all state on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 if_req  in  1  fetch request; held until if_done.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_rdata  out  32  fetched instruction, valid while if_done=1.
REQ-007 if_done  out  1  one-cycle fetch completion pulse.
REQ-008 d_req  in  1  data-stage request; held until d_done.
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_addr / d_wdata  in  32 / 32  data address, store data.
REQ-011 d_ubhw  in  3  access width/sign (funct3 encoding).
REQ-012 d_rdata  out  32  load data, valid while d_done=1.
REQ-013 d_done  out  1  one-cycle data completion pulse.
REQ-014 m_req / m_we  out  1 / 1  shared-port request, write enable.
REQ-015 m_addr / m_wdata  out  32 / 32  shared-port address, write data.
REQ-016 m_ubhw  out  3  shared-port width.
REQ-017 m_rdata / m_ack  in  32 / 1  port read data; access complete.
REQ-018 if_stall / d_stall  out  1 / 1  pipeline stall: *_req & ~*_done (combinational).
REQ-019 bus_err  out  1  timeout pulse, coincident with the aborted requester's done.

Function
REQ-020 FSM SHALL have states IDLE, GNT_IF, GNT_D.
REQ-021 IDLE: eligible requester granted next edge; address/data/we/ubhw latched into port registers at grant.
REQ-022 Requester whose done is 1 this cycle SHALL be ineligible this cycle (no re-grant on stale req).
REQ-023 Both eligible: d_req wins (fixed priority, data stage older).
REQ-024 GNT_*: m_req=1, port outputs from latched registers; input changes ignored until completion.
REQ-025 m_ack=1 in GNT_*: next edge -> IDLE, granted requester's done=1 for exactly one cycle, rdata = m_rdata captured (stores: d_rdata=0).
REQ-026 Minimum latency: req seen cycle 0, m_req cycle 1, done cycle 2 if m_ack in cycle 1.
REQ-027 m_ack outside GNT_* SHALL be ignored.
REQ-028 Wait counter (width ceil(log2(TIMEOUT_CYCLES+1))) counts GNT_* cycles with m_ack=0, cleared on grant.
REQ-029 Counter reaching TIMEOUT_CYCLES with m_ack=0: next edge -> IDLE, m_req drops, done and bus_err pulse, rdata=0.
REQ-030 m_ack on the timeout cycle SHALL take precedence (normal completion, no bus_err).
REQ-031 Requester deasserting req mid-grant: access completes, done still pulses.
REQ-032 if_done and d_done SHALL never be 1 in the same cycle.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, counter 0, m_req/m_we=0, m_addr/m_wdata/m_ubhw=0, if_done/d_done/bus_err=0, if_rdata/d_rdata=0, last-grant=IF.
REQ-034 Reset mid-grant SHALL abandon the access; no done pulse after release.

Configuration
REQ-035 Macro MEM_ARB_RR_EN defined: both eligible -> grant the requester not granted last (round-robin; first contention after reset goes to D).
REQ-036 MEM_ARB_RR_EN undefined: fixed D-over-IF priority per REQ-023; last-grant register absent.

Verification
REQ-037 if_req=1, if_addr=0x04, m_ack at first m_req cycle, m_rdata=0x00A00093 -> m_addr=0x04 cycle 1, if_done+if_rdata=0x00A00093 cycle 2, if_stall 0 on cycle 2.
REQ-038 if_req, d_req rise together (d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF), ack each in 1 cycle -> D served first (m_we=1), IF granted next; with MEM_ARB_RR_EN, repeated contention alternates D,IF,D.
REQ-039 d_req load, m_ack held 0 with TIMEOUT_CYCLES=16 -> m_req high 16 cycles, then d_done+bus_err together, d_rdata=0.
REQ-040 m_ack asserted on 16th wait cycle -> normal d_done, bus_err=0, d_rdata=m_rdata.
REQ-041 rst pulled low during GNT_IF wait -> m_req=0 same cycle; after release, no if_done until if_req re-arbitrated.
REQ-042 if_req held high across done, new if_addr=0x08 -> no grant on done cycle, new access at 0x08 granted next IDLE cycle.
